// File: rtl/kitten_axil_regs_mt.sv
// rtl/kitten_axil_regs_mt.sv - multi-tile AXI-Lite control/status register block
module kitten_axil_regs_mt #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_TILES  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [NUM_TILES-1:0]      o_step_start,
    output logic [NUM_TILES-1:0]      o_proj_done,
    output logic [16*NUM_TILES-1:0]   o_alpha,
    output logic [16*NUM_TILES-1:0]   o_v_th,
    output logic [16*NUM_TILES-1:0]   o_scale_q,
    output logic                      o_irq,
    input  logic [NUM_TILES-1:0]      i_step_done,
    input  logic [NUM_TILES-1:0]      i_busy
);

    localparam int NT = NUM_TILES;
    localparam int WA = ADDR_WIDTH - 2;   // word address width
    localparam int XW = ADDR_WIDTH - 5;   // tile index width
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [15:0] ALPHA_RST = 16'd14746;
    localparam logic [15:0] VTH_RST   = 16'd8192;
    localparam logic [15:0] SCALE_RST = 16'd16384;

    logic          aw_held, w_held, aw_held_n, w_held_n, bvalid_n, rvalid_n;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic [WA-1:0] aw_word, ar_word;
    logic [15:0]   w_data_q, wmask;
    logic [1:0]    w_strb_q;
    logic [NT-1:0] done_q, irq_en_q, prev_q, proj_done_q;
    logic [15:0]   alpha_q [NT];
    logic [15:0]   vth_q   [NT];
    logic [15:0]   scale_q [NT];

    logic [WA-1:0] w_off, r_off;
    logic [XW-1:0] w_tidx, r_tidx;
    logic [2:0]    w_treg, r_treg;
    logic          w_glob, r_glob, w_tile_ok, r_tile_ok;
    logic          wr_err, irq_we, tile_we, rd_err;
    logic [NT-1:0] go_req, done_clr;
    logic [DATA_WIDTH-1:0] rd_val;

    // Address bits below the word and data above the 16-bit registers carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0],
                           s_axil_wdata[DATA_WIDTH-1:16], s_axil_wstrb[DATA_WIDTH/8-1:2]};

    // Handshake qualifiers and next state of the channel flags.
    always_comb begin
        aw_hs     = s_axil_awvalid & s_axil_awready;
        w_hs      = s_axil_wvalid & s_axil_wready;
        ar_hs     = s_axil_arvalid & s_axil_arready;
        commit    = aw_held & w_held;
        aw_held_n = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_held);
        w_held_n  = commit ? 1'b0 : (w_hs ? 1'b1 : w_held);
        bvalid_n  = commit ? 1'b1 : ((s_axil_bvalid & s_axil_bready) ? 1'b0 : s_axil_bvalid);
        rvalid_n  = ar_hs ? 1'b1 : ((s_axil_rvalid & s_axil_rready) ? 1'b0 : s_axil_rvalid);
        wmask     = {{8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
    end

    // Decode the latched write address into register actions, only active on the commit cycle.
    always_comb begin
        w_glob    = (aw_word[WA-1:6] == '0);
        w_off     = aw_word - WA'(64);
        w_tidx    = w_off[WA-1:3];
        w_treg    = w_off[2:0];
        w_tile_ok = !w_glob && (int'(w_tidx) < NT) && (w_treg < 3'd4);
        wr_err    = 1'b0;
        go_req    = '0;
        done_clr  = '0;
        irq_we    = 1'b0;
        tile_we   = 1'b0;
        if (commit) begin
            if (w_glob) begin
                case (aw_word[5:0])
                    6'd1:    go_req   = w_data_q[NT-1:0] & wmask[NT-1:0];
                    6'd2:    done_clr = w_data_q[NT-1:0] & wmask[NT-1:0];
                    6'd3:    irq_we   = 1'b1;
                    default: wr_err   = 1'b1;
                endcase
            end else if (w_tile_ok) begin
                tile_we = 1'b1;
            end else begin
                wr_err = 1'b1;
            end
        end
    end

    // Read mux straight off the AR address; captured into rdata at the handshake.
    always_comb begin
        ar_word   = s_axil_araddr[ADDR_WIDTH-1:2];
        r_glob    = (ar_word[WA-1:6] == '0);
        r_off     = ar_word - WA'(64);
        r_tidx    = r_off[WA-1:3];
        r_treg    = r_off[2:0];
        r_tile_ok = !r_glob && (int'(r_tidx) < NT) && (r_treg < 3'd4);
        rd_val    = '0;
        rd_err    = 1'b0;
        if (r_glob) begin
            case (ar_word[5:0])
                6'd0:    rd_val = {16'h4B46, 8'h02, 8'(NT)};
                6'd1:    rd_val = '0;
                6'd2:    rd_val = DATA_WIDTH'(done_q);
                6'd3:    rd_val = DATA_WIDTH'(irq_en_q);
                6'd4:    rd_val = DATA_WIDTH'(i_busy);
                default: rd_err = 1'b1;
            endcase
        end else if (r_tile_ok) begin
            for (int t = 0; t < NT; t++) begin
                if (r_tidx == XW'(t)) begin
                    case (r_treg)
                        3'd0:    rd_val[1] = proj_done_q[t];
                        3'd1:    rd_val = DATA_WIDTH'(alpha_q[t]);
                        3'd2:    rd_val = DATA_WIDTH'(vth_q[t]);
                        3'd3:    rd_val = DATA_WIDTH'(scale_q[t]);
                        default: rd_val = '0;
                    endcase
                end
            end
        end else begin
            rd_err = 1'b1;
        end
        if (rd_err) begin
            rd_val = 32'hDEADBEEF;
        end
    end

    // Write channel: latch AW and W independently, respond once both are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_word        <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
        end else begin
            aw_held        <= aw_held_n;
            w_held         <= w_held_n;
            s_axil_bvalid  <= bvalid_n;
            s_axil_awready <= !aw_held_n && !bvalid_n;
            s_axil_wready  <= !w_held_n && !bvalid_n;
            if (aw_hs) begin
                aw_word <= s_axil_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_data_q <= s_axil_wdata[15:0];
                w_strb_q <= s_axil_wstrb[1:0];
            end
            if (commit) begin
                s_axil_bresp <= (wr_err || (|(go_req & i_busy))) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Register file, start pulses, sticky done capture (set beats clear) and interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q       <= '0;
            irq_en_q     <= '0;
            prev_q       <= '0;
            proj_done_q  <= '0;
            o_step_start <= '0;
            o_irq        <= 1'b0;
            for (int t = 0; t < NT; t++) begin
                alpha_q[t] <= ALPHA_RST;
                vth_q[t]   <= VTH_RST;
                scale_q[t] <= SCALE_RST;
            end
        end else begin
            prev_q       <= i_step_done;
            done_q       <= (done_q & ~done_clr) | (i_step_done & ~prev_q);
            o_irq        <= |(done_q & irq_en_q);
            o_step_start <= go_req & ~i_busy;
            if (irq_we) begin
                irq_en_q <= (irq_en_q & ~wmask[NT-1:0]) | (w_data_q[NT-1:0] & wmask[NT-1:0]);
            end
            for (int t = 0; t < NT; t++) begin
                if (tile_we && (w_tidx == XW'(t))) begin
                    case (w_treg)
                        3'd0: if (w_strb_q[0]) proj_done_q[t] <= w_data_q[1];
                        3'd1: alpha_q[t] <= (alpha_q[t] & ~wmask) | (w_data_q & wmask);
                        3'd2: vth_q[t]   <= (vth_q[t] & ~wmask) | (w_data_q & wmask);
                        3'd3: scale_q[t] <= (scale_q[t] & ~wmask) | (w_data_q & wmask);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Read channel: one outstanding read, data held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rdata   <= '0;
        end else begin
            s_axil_rvalid  <= rvalid_n;
            s_axil_arready <= !rvalid_n;
            if (ar_hs) begin
                s_axil_rdata <= rd_val;
                s_axil_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Flatten per-tile parameters onto the output buses.
    always_comb begin
        o_proj_done = proj_done_q;
        for (int t = 0; t < NT; t++) begin
            o_alpha[16*t +: 16]   = alpha_q[t];
            o_v_th[16*t +: 16]    = vth_q[t];
            o_scale_q[16*t +: 16] = scale_q[t];
        end
    end

endmodule
